// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded operands, register indices and control bits from ID
// and presents them to EX and the forwarding unit. It inserts a bubble
// (all fields zero) on a branch flush or a load-use hazard, and freezes on
// MEM back-pressure. A saturating counter tracks load-use bubbles.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   mem_busy            MEM not ready: hold every register in this stage
//   flush               squash the instruction currently in ID
//   if_id_*             decoded fields from ID (indices, controls, data)
//   id_ex_*             registered fields to EX / forwarding unit
//   pc_write            PC may advance (combinational)
//   if_id_write         IF/ID may load (combinational)
//   bubble_count        saturating count of load-use bubbles
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_busy,
  input  logic              flush,
  input  logic [REG_W-1:0]  if_id_registerA,
  input  logic [REG_W-1:0]  if_id_registerB,
  input  logic [REG_W-1:0]  if_id_registerRD,
  input  logic              if_id_usesB,
  input  logic              if_id_regWrite,
  input  logic              if_id_memRead,
  input  logic              if_id_memWrite,
  input  logic              if_id_ALUSrc,
  input  logic [3:0]        if_id_aluOp,
  input  logic [DATA_W-1:0] if_id_dataA,
  input  logic [DATA_W-1:0] if_id_dataB,
  input  logic [DATA_W-1:0] if_id_imm,
  output logic [REG_W-1:0]  id_ex_registerA,
  output logic [REG_W-1:0]  id_ex_registerB,
  output logic [REG_W-1:0]  id_ex_registerRD,
  output logic              id_ex_regWrite,
  output logic              id_ex_memRead,
  output logic              id_ex_memWrite,
  output logic              id_ex_ALUSrc,
  output logic [3:0]        id_ex_aluOp,
  output logic [DATA_W-1:0] id_ex_dataA,
  output logic [DATA_W-1:0] id_ex_dataB,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic [REG_W-1:0]  reg_a;
    logic [REG_W-1:0]  reg_b;
    logic [REG_W-1:0]  reg_rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] imm;
  } ex_fields_t;

  ex_fields_t       ex_d, ex_q, id_fields;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             load_use;

  assign id_fields = '{
    reg_a:     if_id_registerA,
    reg_b:     if_id_registerB,
    reg_rd:    if_id_registerRD,
    reg_write: if_id_regWrite,
    mem_read:  if_id_memRead,
    mem_write: if_id_memWrite,
    alu_src:   if_id_ALUSrc,
    alu_op:    if_id_aluOp,
    data_a:    if_id_dataA,
    data_b:    if_id_dataB,
    imm:       if_id_imm
  };

  // A bubble clears memRead, so a hazard can never be raised twice for the
  // same ID instruction: exactly one bubble per load-use.
  assign load_use = ex_q.mem_read &&
                    ((ex_q.reg_rd == if_id_registerA) ||
                     (if_id_usesB && (ex_q.reg_rd == if_id_registerB)));

  // Flush does not stall the front end: IF must fetch the branch target.
  assign pc_write    = !(mem_busy || load_use);
  assign if_id_write = !(mem_busy || load_use);

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!mem_busy) begin
      if (flush) begin
        // Flush bubbles are not counted, even when a hazard coincides.
        ex_d = '0;
      end else if (load_use) begin
        ex_d = '0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end else begin
        ex_d = id_fields;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign id_ex_registerA  = ex_q.reg_a;
  assign id_ex_registerB  = ex_q.reg_b;
  assign id_ex_registerRD = ex_q.reg_rd;
  assign id_ex_regWrite   = ex_q.reg_write;
  assign id_ex_memRead    = ex_q.mem_read;
  assign id_ex_memWrite   = ex_q.mem_write;
  assign id_ex_ALUSrc     = ex_q.alu_src;
  assign id_ex_aluOp      = ex_q.alu_op;
  assign id_ex_dataA      = ex_q.data_a;
  assign id_ex_dataB      = ex_q.data_b;
  assign id_ex_imm        = ex_q.imm;
  assign bubble_count     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  logic clock = 1'b0;
  logic reset, mem_busy, flush;
  logic [REG_W-1:0]  ia, ib, ird;
  logic              iusesb, irw, imr, imw, ias;
  logic [3:0]        iop;
  logic [DATA_W-1:0] ida, idb, iimm;

  logic [REG_W-1:0]  oa, ob, ord, sa, sb, srd;
  logic              orw, omr, omw, oas, srw, smr, smw, sas;
  logic [3:0]        oop, sop;
  logic [DATA_W-1:0] oda, odb, oimm, sda, sdb, simm;
  logic              pcw, ifw, spcw, sifw;
  logic [15:0]       cnt;
  logic [1:0]        scnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .mem_busy(mem_busy), .flush(flush),
    .if_id_registerA(ia), .if_id_registerB(ib), .if_id_registerRD(ird),
    .if_id_usesB(iusesb), .if_id_regWrite(irw), .if_id_memRead(imr),
    .if_id_memWrite(imw), .if_id_ALUSrc(ias), .if_id_aluOp(iop),
    .if_id_dataA(ida), .if_id_dataB(idb), .if_id_imm(iimm),
    .id_ex_registerA(oa), .id_ex_registerB(ob), .id_ex_registerRD(ord),
    .id_ex_regWrite(orw), .id_ex_memRead(omr), .id_ex_memWrite(omw),
    .id_ex_ALUSrc(oas), .id_ex_aluOp(oop), .id_ex_dataA(oda),
    .id_ex_dataB(odb), .id_ex_imm(oimm), .pc_write(pcw),
    .if_id_write(ifw), .bubble_count(cnt)
  );

  // Narrow-counter instance, shares stimulus; only its counter is checked.
  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(2)) sat (
    .clock(clock), .reset(reset), .mem_busy(mem_busy), .flush(flush),
    .if_id_registerA(ia), .if_id_registerB(ib), .if_id_registerRD(ird),
    .if_id_usesB(iusesb), .if_id_regWrite(irw), .if_id_memRead(imr),
    .if_id_memWrite(imw), .if_id_ALUSrc(ias), .if_id_aluOp(iop),
    .if_id_dataA(ida), .if_id_dataB(idb), .if_id_imm(iimm),
    .id_ex_registerA(sa), .id_ex_registerB(sb), .id_ex_registerRD(srd),
    .id_ex_regWrite(srw), .id_ex_memRead(smr), .id_ex_memWrite(smw),
    .id_ex_ALUSrc(sas), .id_ex_aluOp(sop), .id_ex_dataA(sda),
    .id_ex_dataB(sdb), .id_ex_imm(simm), .pc_write(spcw),
    .if_id_write(sifw), .bubble_count(scnt)
  );

  wire [19:0] ctl  = {oa, ob, ord, orw, omr, omw, oas, oop};
  wire [95:0] data = {oda, odb, oimm};

  function automatic logic [19:0] mk_ctl(input logic [3:0] a, b, rd,
                                         input logic rw, mr, mw, as,
                                         input logic [3:0] op);
    return {a, b, rd, rw, mr, mw, as, op};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, b, rd, input logic ub, rw, mr, mw, as,
                       input logic [3:0] op, input logic [31:0] da, db, im);
    ia = a; ib = b; ird = rd; iusesb = ub; irw = rw; imr = mr; imw = mw;
    ias = as; iop = op; ida = da; idb = db; iimm = im;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [19:0] held_ctl;
  logic [95:0] held_data;

  initial begin
    reset = 1'b1; mem_busy = 1'b0; flush = 1'b0;
    // Reset with random ID fields for two clocks.
    drive($urandom, $urandom, $urandom, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
          $urandom, $urandom, $urandom, $urandom);
    tick(); tick();
    chk("reset_ctl", ctl, 0);
    chk("reset_data", data, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_sat_cnt", scnt, 0);

    // First edge after release: normal load of LW RD=3.
    reset = 1'b0;
    drive(4'd1, 4'd2, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 32'd100, 32'd200, 32'd8);
    chk("release_pc_write", pcw, 1);
    tick();
    chk("lw_ctl", ctl, mk_ctl(1, 2, 3, 1, 1, 0, 1, 2));
    chk("lw_data", data, {32'd100, 32'd200, 32'd8});

    // Dependent on A=3: one-cycle stall and one counted bubble.
    drive(4'd3, 4'd4, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 32'd11, 32'd22, 32'd0);
    chk("lu_pc_write", pcw, 0);
    chk("lu_if_id_write", ifw, 0);
    tick();
    chk("lu_bubble_ctl", ctl, 0);
    chk("lu_bubble_data", data, 0);
    chk("lu_cnt", cnt, 1);
    chk("lu_after_pc_write", pcw, 1);
    tick();
    chk("lu_dep_ctl", ctl, mk_ctl(3, 4, 6, 1, 0, 0, 0, 1));
    chk("lu_dep_data", data, {32'd11, 32'd22, 32'd0});
    chk("lu_dep_cnt", cnt, 1);

    // usesB gating: B matches but usesB=0 -> no stall.
    drive(4'd7, 4'd8, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 32'd1, 32'd2, 32'd3);
    tick();
    drive(4'd9, 4'd5, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 32'd4, 32'd5, 32'd5);
    chk("usesb0_pc_write", pcw, 1);
    tick();
    chk("usesb0_ctl", ctl, mk_ctl(9, 5, 10, 1, 0, 0, 1, 3));
    chk("usesb0_cnt", cnt, 1);
    // Same with usesB=1 -> one bubble.
    drive(4'd7, 4'd8, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 32'd1, 32'd2, 32'd3);
    tick();
    drive(4'd9, 4'd5, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 32'd4, 32'd5, 32'd5);
    chk("usesb1_pc_write", pcw, 0);
    tick();
    chk("usesb1_bubble", ctl, 0);
    chk("usesb1_cnt", cnt, 2);
    tick();
    chk("usesb1_dep_ctl", ctl, mk_ctl(9, 5, 10, 1, 0, 0, 0, 3));

    // Flush coinciding with load-use: bubble, count unchanged, stall seen.
    drive(4'd0, 4'd0, 4'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 32'd7, 32'd8, 32'd9);
    tick();
    drive(4'd12, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 32'd6, 32'd6, 32'd6);
    flush = 1'b1;
    #1;
    chk("flush_lu_pc_write", pcw, 0);
    tick();
    chk("flush_lu_ctl", ctl, 0);
    chk("flush_lu_data", data, 0);
    chk("flush_lu_cnt", cnt, 2);
    // Flush alone keeps the PC moving.
    chk("flush_only_pc_write", pcw, 1);
    tick();
    chk("flush_only_ctl", ctl, 0);
    chk("flush_only_cnt", cnt, 2);
    flush = 1'b0;

    // mem_busy hold for 3 cycles with changing ID fields.
    drive(4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 32'hAAAA, 32'hBBBB, 32'hCCCC);
    tick();
    held_ctl  = mk_ctl(2, 3, 4, 1, 0, 0, 0, 5);
    held_data = {32'hAAAA, 32'hBBBB, 32'hCCCC};
    chk("pre_hold_ctl", ctl, held_ctl);
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(4'(k + 5), 4'(k + 6), 4'(k + 7), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
            4'(k), 32'(k), 32'(k), 32'(k));
      chk("hold_pc_write", pcw, 0);
      chk("hold_if_id_write", ifw, 0);
      tick();
      chk("hold_ctl", ctl, held_ctl);
      chk("hold_data", data, held_data);
    end
    mem_busy = 1'b0;
    drive(4'd1, 4'd2, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 32'd50, 32'd60, 32'd70);
    tick();
    chk("release_load_ctl", ctl, mk_ctl(1, 2, 7, 1, 1, 0, 1, 2));
    chk("release_load_data", data, {32'd50, 32'd60, 32'd70});

    // Load-use pending under mem_busy bubbles on the release edge.
    drive(4'd7, 4'd0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 32'd1, 32'd1, 32'd1);
    mem_busy = 1'b1;
    #1;
    tick(); tick();
    chk("pend_hold_ctl", ctl, mk_ctl(1, 2, 7, 1, 1, 0, 1, 2));
    chk("pend_hold_cnt", cnt, 2);
    mem_busy = 1'b0;
    #1;
    chk("pend_release_pc_write", pcw, 0);
    tick();
    chk("pend_bubble_ctl", ctl, 0);
    chk("pend_bubble_cnt", cnt, 3);
    tick();
    chk("pend_dep_ctl", ctl, mk_ctl(7, 0, 8, 1, 0, 0, 0, 6));

    // Reset mid-hold overrides mem_busy.
    mem_busy = 1'b1; reset = 1'b1;
    tick();
    chk("reset_hold_ctl", ctl, 0);
    chk("reset_hold_cnt", cnt, 0);
    mem_busy = 1'b0; reset = 1'b0;

    // Saturation: five load-use bubbles.
    for (int k = 0; k < 5; k++) begin
      drive(4'd0, 4'd0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 32'd0, 32'd0, 32'd4);
      tick();
      drive(4'd1, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 32'd0, 32'd0, 32'd0);
      tick();
      chk("sat_cnt_w2", scnt, (k + 1 > 3) ? 3 : k + 1);
      chk("sat_cnt_w16", cnt, k + 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL timeout vectors=%0d", vectors);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the Lapido pipeline. It captures decoded operands, register indices and control bits from ID and presents them to EX and the forwarding unit. It also inserts bubbles on load-use hazards or branch flushes, and holds on memory back-pressure. A saturating bubble counter is provided for performance inspection.

## Interface
- DATA_W, 32, operand and immediate width
- REG_W, 4, register index width (16 registers)
- CNT_W, 16, bubble counter width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- mem_busy  in  1  MEM stage not ready; freezes this stage
- flush  in  1  branch taken/mispredict resolved in EX; squash the instruction in ID
- if_id_registerA / if_id_registerB / if_id_registerRD  in  REG_W  source/dest indices decoded in ID
- if_id_usesB  in  1  instruction in ID reads registerB (ALUSrc==0 or store)
- if_id_regWrite, if_id_memRead, if_id_memWrite, if_id_ALUSrc  in  1  decoded control bits
- if_id_aluOp  in  4  ALU operation
- if_id_dataA / if_id_dataB / if_id_imm  in  DATA_W  register-file reads and sign-extended immediate
- id_ex_registerA / id_ex_registerB / id_ex_registerRD  out  REG_W  registered indices to EX/FU
- id_ex_regWrite, id_ex_memRead, id_ex_memWrite, ALUSrc  out  1  registered control bits
- id_ex_aluOp  out  4; id_ex_dataA / id_ex_dataB / id_ex_imm  out  DATA_W
- pc_write  out  1  PC may advance (combinational)
- if_id_write  out  1  IF/ID register may load (combinational)
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Hazard (combinational): load_use = id_ex_memRead && id_ex_registerRD == if_id_registerA, or id_ex_memRead && if_id_usesB && id_ex_registerRD == if_id_registerB.
- Action priority per rising edge, highest first:
  - reset: all outputs 0, bubble_count 0.
  - mem_busy: every id_ex_* register holds; bubble_count holds.
  - flush: load bubble.
  - load_use: load bubble; bubble_count increments.
  - else: load all if_id_* fields.
- Bubble definition:
  - regWrite, memRead, memWrite, ALUSrc cleared; aluOp = 0.
  - registerRD = 0, registerA/B = 0.
  - data/imm fields = 0.
  - A bubble must never match a forwarding or hazard comparison with regWrite set.
- pc_write = if_id_write = !(mem_busy || load_use). flush does not deassert them; IF must fetch the target.
- When flush and load_use coincide, flush wins. bubble_count does not increment, since a flush bubble is not counted.
- bubble_count saturates at 2^CNT_W-1 and does not wrap.
- Register RD = 0 is an ordinary register here; no special zero-register suppression.

## Timing
- Latency: ID fields appear on id_ex_* one clock after the edge at which they are loaded.
- load_use is evaluated against current id_ex_* outputs. Exactly one bubble is inserted per load-use, because the bubble clears id_ex_memRead, so the next cycle reloads the held ID instruction.
- A load followed by two dependent instructions yields one bubble total.
- mem_busy asserted for N cycles holds contents for N edges. pc_write/if_id_write are low during those cycles.
- If load_use is pending while mem_busy is high, the bubble is inserted on the first edge with mem_busy low.
- reset asserted mid-hold or mid-bubble overrides everything on that edge. The first edge after reset deasserts performs a normal load unless a hazard exists.
- All outputs except pc_write/if_id_write are registered; those two are combinational from id_ex_* registers and inputs.

## Test plan
- Reset: drive random ID fields, reset=1 for 2 clocks -> all id_ex_* and bubble_count = 0; pc_write=1 after release with no hazard.
- Load-use: LW RD=3 enters EX, ID has registerA=3 -> pc_write=if_id_write=0 for 1 cycle, next id_ex_regWrite=0/RD=0, bubble_count=1, following cycle the dependent instruction (A=3) appears.
- usesB gating: LW RD=5 in EX, ID registerB=5, if_id_usesB=0 -> no stall, bubble_count=0; with usesB=1 -> one bubble.
- Flush vs load-use same cycle: flush=1 and hazard present -> bubble loaded, bubble_count unchanged, pc_write=0 from hazard that cycle.
- mem_busy hold: mem_busy=1 for 3 cycles with changing ID inputs -> id_ex_* stable, pc_write=0; after release the next ID value loads; a pending load-use bubbles on the release edge.
- Saturation: CNT_W=2, force 5 load-use hazards -> bubble_count 1,2,3,3,3.
